// File: rtl/vector_cache_pkg.sv
// Shared vector-cache types plus the east read-data collector's beat layout,
// FSM encoding and round-robin helper.
package vector_cache_pkg;

    localparam int VEC_EAST_COLL_DEPTH = 4;
    localparam int VEC_EAST_LANES      = 8;

    typedef logic [31:0] group_data_pld_t;
    typedef logic [5:0]  txnid_t;

    typedef struct packed {
        txnid_t          txnid;
        group_data_pld_t data;
    } east_rdata_beat_t;

    typedef enum logic {
        COLL_IDLE = 1'b0,
        COLL_HOLD = 1'b1
    } coll_state_t;

    function automatic logic [2:0] rr_next(input logic [2:0] lane);
        return (lane == 3'(VEC_EAST_LANES - 1)) ? 3'd0 : lane + 3'd1;
    endfunction

endpackage

// File: rtl/vec_cache_lane_fifo.sv
// Single-lane beat FIFO: registered storage, combinational head read,
// pointers carry one extra wrap bit so cnt = wr - rd distinguishes full from empty.
module vec_cache_lane_fifo
    import vector_cache_pkg::*;
#(
    parameter  int FIFO_DEPTH = VEC_EAST_COLL_DEPTH,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  east_rdata_beat_t push_data_i,
    input  logic             pop_i,
    output east_rdata_beat_t pop_data_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    east_rdata_beat_t mem_q [FIFO_DEPTH];
    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             push_en, pop_en;

    assign cnt_o   = wr_ptr_q - rd_ptr_q;
    assign empty_o = (cnt_o == '0);
    assign full_o  = (cnt_o == CNT_W'(FIFO_DEPTH));

    // Full is judged on the pre-cycle count, so a pop cannot make room for a same-cycle push.
    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

    assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/vec_cache_east_rdata_collector.sv
// Buffers the eight east loop-back lanes and round-robin merges them onto one
// valid/ready return channel; lane overflow is flagged sticky, never stalled.
module vec_cache_east_rdata_collector
    import vector_cache_pkg::*;
#(
    parameter  int LANES      = VEC_EAST_LANES,
    parameter  int FIFO_DEPTH = VEC_EAST_COLL_DEPTH,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [LANES-1:0] in_vld,
    input  group_data_pld_t in_data  [LANES],
    input  txnid_t          in_txnid [LANES],
    output logic            out_vld,
    input  logic            out_rdy,
    output group_data_pld_t out_data,
    output txnid_t          out_txnid,
    output logic [2:0]      out_lane,
    output logic [LANES-1:0] ovf_err,
    output logic [LANES-1:0] lane_empty
);

    coll_state_t      state_q, state_d;
    logic [2:0]       rr_ptr_q, rr_ptr_d;
    logic [2:0]       grant_q, grant_d;
    logic [LANES-1:0] ovf_q, ovf_d;

    east_rdata_beat_t head   [LANES];
    logic [CNT_W-1:0] lane_cnt [LANES];
    logic [LANES-1:0] lane_full;
    logic [LANES-1:0] pop_vec;
    logic [2:0]       cand, scan_idx, sel;
    logic             any_pending, found;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        east_rdata_beat_t push_beat;
        assign push_beat.txnid = in_txnid[i];
        assign push_beat.data  = in_data[i];

        vec_cache_lane_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .push_i      (in_vld[i]),
            .push_data_i (push_beat),
            .pop_i       (pop_vec[i]),
            .pop_data_o  (head[i]),
            .cnt_o       (lane_cnt[i]),
            .empty_o     (lane_empty[i]),
            .full_o      (lane_full[i])
        );

        a_cnt_bound : assert property (@(posedge clk) disable iff (rst)
            lane_cnt[i] <= CNT_W'(FIFO_DEPTH));
    end

    assign any_pending = |(~lane_empty);

    // First non-empty lane scanning upward from rr_ptr, wrapping at LANES.
    always_comb begin
        cand     = rr_ptr_q;
        scan_idx = rr_ptr_q;
        found    = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            scan_idx = 3'((int'(rr_ptr_q) + k) % LANES);
            if (!found && !lane_empty[scan_idx]) begin
                cand  = scan_idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        sel      = grant_q;
        out_vld  = 1'b0;
        pop_vec  = '0;
        case (state_q)
            COLL_IDLE: begin
                sel     = cand;
                out_vld = any_pending;
                if (any_pending) begin
                    if (out_rdy) begin
                        pop_vec[cand] = 1'b1;
                        rr_ptr_d      = rr_next(cand);
                    end else begin
                        grant_d = cand;
                        state_d = COLL_HOLD;
                    end
                end
            end
            COLL_HOLD: begin
                sel     = grant_q;
                out_vld = 1'b1;
                if (out_rdy) begin
                    pop_vec[grant_q] = 1'b1;
                    rr_ptr_d         = rr_next(grant_q);
                    state_d          = COLL_IDLE;
                end
            end
            default: state_d = COLL_IDLE;
        endcase
    end

    assign ovf_d = ovf_q | (in_vld & lane_full);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= COLL_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            ovf_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_data  = head[sel].data;
    assign out_txnid = head[sel].txnid;
    assign out_lane  = (state_q == COLL_IDLE && !any_pending) ? 3'd0 : sel;
    assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_vec_cache_east_rdata_collector.sv
// Scoreboard bench for the east read-data collector: expected beats are queued
// as lanes are driven and checked in order as the merged channel hands them off.
module tb_vec_cache_east_rdata_collector;
    import vector_cache_pkg::*;

    localparam int LANES = 8;

    logic            clk;
    logic            rst;
    logic [LANES-1:0] in_vld;
    group_data_pld_t in_data  [LANES];
    txnid_t          in_txnid [LANES];
    logic            out_vld;
    logic            out_rdy;
    group_data_pld_t out_data;
    txnid_t          out_txnid;
    logic [2:0]      out_lane;
    logic [LANES-1:0] ovf_err;
    logic [LANES-1:0] lane_empty;

    vec_cache_east_rdata_collector dut (
        .clk        (clk),
        .rst        (rst),
        .in_vld     (in_vld),
        .in_data    (in_data),
        .in_txnid   (in_txnid),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .out_data   (out_data),
        .out_txnid  (out_txnid),
        .out_lane   (out_lane),
        .ovf_err    (ovf_err),
        .lane_empty (lane_empty)
    );

    typedef struct packed {
        logic [2:0]      lane;
        txnid_t          txnid;
        group_data_pld_t data;
    } exp_t;

    exp_t            sb [$];
    exp_t            e;
    group_data_pld_t last_data [LANES];
    txnid_t          last_txn  [LANES];
    int              n_cmp = 0;
    int              n_mis = 0;
    logic            hold_prev = 1'b0;
    logic [2:0]      prev_lane;
    group_data_pld_t prev_data;
    txnid_t          prev_txnid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at posedge+1; holds the beats for one clock then clears them.
    task automatic drive(input logic [LANES-1:0] mask);
        for (int i = 0; i < LANES; i++) begin
            if (mask[i]) begin
                last_data[i] = $urandom;
                last_txn[i]  = txnid_t'($urandom);
                in_data[i]   = last_data[i];
                in_txnid[i]  = last_txn[i];
            end else begin
                in_data[i]  = 'x;
                in_txnid[i] = 'x;
            end
        end
        in_vld = mask;
        @(posedge clk);
        #1;
        in_vld = '0;
        for (int i = 0; i < LANES; i++) begin
            in_data[i]  = 'x;
            in_txnid[i] = 'x;
        end
    endtask

    task automatic expect_beat(input int l);
        sb.push_back('{lane: 3'(l), txnid: last_txn[l], data: last_data[l]});
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Output monitor: scoreboard pop on handshake, stability while stalled.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    chk("hold_vld", 64'(out_vld), 64'd1);
                    chk("hold_lane", 64'(out_lane), 64'(prev_lane));
                    chk("hold_data", 64'(out_data), 64'(prev_data));
                    chk("hold_txnid", 64'(out_txnid), 64'(prev_txnid));
                end
                if (out_vld && out_rdy) begin
                    if (sb.size() == 0) begin
                        chk("stale_beat", 64'(out_vld), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("beat_lane", 64'(out_lane), 64'(e.lane));
                        chk("beat_txnid", 64'(out_txnid), 64'(e.txnid));
                        chk("beat_data", 64'(out_data), 64'(e.data));
                    end
                end
                hold_prev  = out_vld && !out_rdy;
                prev_lane  = out_lane;
                prev_data  = out_data;
                prev_txnid = out_txnid;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        in_vld  = '0;
        out_rdy = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            in_data[i]  = 'x;
            in_txnid[i] = 'x;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset then idle
        repeat (10) begin
            @(negedge clk);
            chk("idle_vld", 64'(out_vld), 64'd0);
        end
        chk("idle_empty", 64'(lane_empty), 64'hFF);
        chk("idle_ovf", 64'(ovf_err), 64'd0);
        chk("idle_lane", 64'(out_lane), 64'd0);
        @(posedge clk);
        #1;

        // Single beat on lane 2
        out_rdy     = 1'b1;
        last_data[2] = $urandom;
        last_txn[2]  = 6'd5;
        in_data[2]   = last_data[2];
        in_txnid[2]  = last_txn[2];
        in_vld       = 8'h04;
        expect_beat(2);
        @(negedge clk);
        chk("single_pre_vld", 64'(out_vld), 64'd0);
        @(posedge clk);
        #1;
        in_vld = '0;
        @(negedge clk);
        chk("single_vld", 64'(out_vld), 64'd1);
        chk("single_lane", 64'(out_lane), 64'd2);
        chk("single_txnid", 64'(out_txnid), 64'd5);
        @(negedge clk);
        chk("single_empty2", 64'(lane_empty[2]), 64'd1);
        @(posedge clk);
        #1;
        wait_drain(10);

        // Fairness from rr_ptr=0, then wrap back to 0
        do_reset();
        drive(8'hFF);
        for (int l = 0; l < LANES; l++) expect_beat(l);
        wait_drain(20);
        drive(8'h0A);
        expect_beat(1);
        expect_beat(3);
        wait_drain(10);

        // Backpressure hold on lane 5 while lane 0 arrives
        out_rdy = 1'b0;
        drive(8'h20);
        expect_beat(5);
        drive(8'h01);
        expect_beat(0);
        repeat (5) begin
            @(negedge clk);
            chk("bp_lane", 64'(out_lane), 64'd5);
        end
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
        wait_drain(10);

        // Overflow on lane 1
        out_rdy = 1'b0;
        for (int b = 0; b < 5; b++) begin
            if (b == 4) chk("ovf_before", 64'(ovf_err), 64'd0);
            drive(8'h02);
            if (b < 4) expect_beat(1);
        end
        chk("ovf_set", 64'(ovf_err), 64'h02);
        chk("ovf_empty1", 64'(lane_empty[1]), 64'd0);
        out_rdy = 1'b1;
        wait_drain(20);
        repeat (4) @(posedge clk);
        #1;
        chk("ovf_sticky", 64'(ovf_err), 64'h02);
        chk("ovf_drained", 64'(lane_empty), 64'hFF);

        // Reset mid-drain on lane 6
        out_rdy = 1'b0;
        drive(8'h40);
        expect_beat(6);
        drive(8'h40);
        drive(8'h40);
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_vld_pre", 64'(out_vld), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_vld", 64'(out_vld), 64'd0);
        chk("rst_empty", 64'(lane_empty), 64'hFF);
        chk("rst_ovf", 64'(ovf_err), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_vld", 64'(out_vld), 64'd0);
        chk("post_rst_empty", 64'(lane_empty), 64'hFF);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
